skewed_weight_buffer: RTL and testbench

//  Per-column weight store feeding the top edge of the systolic array. The array reads this

---
 rtl/skewed_weight_buffer.sv | 185 ++++++++++++++++++
 tb/tb_skewed_weight_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/skewed_weight_buffer.sv
// Per-column weight store streamed into the systolic array top edge, column c lagging column 0 by c cycles.
// Optional double banking with run-time bank swap: define WBUF_PINGPONG_EN.
module skewed_weight_buffer #(
    parameter  int COLS  = 4,
    parameter  int DW    = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_col,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ready,
    input  logic                 start,
    input  logic [AW:0]          len,
    input  logic                 swap,
    output logic                 busy,
    output logic                 done,
    output logic                 bank_sel,
    output logic [COLS-1:0]      o_valid,
    output logic [COLS*DW-1:0]   o_data
);
    localparam int          SKW     = (COLS > 1) ? COLS - 1 : 1;
    localparam int          DCW     = $clog2(COLS + 1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [AW:0]        rd_cnt_q, rd_cnt_d, len_q, len_d;
    logic [DCW-1:0]     dr_cnt_q, dr_cnt_d;
    logic               iss_v, done_d, done_q;
    logic               sk_v [SKW];
    logic [AW-1:0]      sk_a [SKW];
    logic [COLS-1:0]    col_v;
    logic [AW-1:0]      col_a [COLS];
    logic [COLS-1:0]    o_valid_q;
    logic [COLS*DW-1:0] o_data_q;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        dr_cnt_d = dr_cnt_q;
        len_d    = len_q;
        done_d   = 1'b0;
        iss_v    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                    len_d    = (len > LEN_MAX) ? LEN_MAX : len;
                end
            end
            STREAM: begin
                iss_v = 1'b1;
                if (rd_cnt_q == len_q - ONE) begin
                    state_d  = DRAIN;
                    dr_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + ONE;
                end
            end
            DRAIN: begin
                // Last column's final word leaves the RAM register one edge before done.
                if (dr_cnt_q == DCW'(COLS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dr_cnt_d = dr_cnt_q + DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            len_q    <= '0;
            dr_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            len_q    <= len_d;
            dr_cnt_q <= dr_cnt_d;
            done_q   <= done_d;
        end
    end

    // Column 0 reads the live address; column c reads stage c-1 of the skew chain.
    always_comb begin
        col_v    = '0;
        col_a    = '{default: '0};
        col_v[0] = iss_v;
        col_a[0] = rd_cnt_q[AW-1:0];
        for (int unsigned c = 1; c < COLS; c++) begin
            col_v[c] = sk_v[c-1];
            col_a[c] = sk_a[c-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKW; i++) begin
                sk_v[i] <= 1'b0;
                sk_a[i] <= '0;
            end
        end else begin
            sk_v[0] <= iss_v;
            sk_a[0] <= rd_cnt_q[AW-1:0];
            for (int unsigned i = 1; i < SKW; i++) begin
                sk_v[i] <= sk_v[i-1];
                sk_a[i] <= sk_a[i-1];
            end
        end
    end

`ifdef WBUF_PINGPONG_EN
    logic [DW-1:0] mem [2][COLS][DEPTH];
    logic          bank_q, pend_q;

    assign wr_ready = 1'b1;
    assign bank_sel = bank_q;

    // Swaps requested mid-tile collapse into a single toggle at the done edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (swap) bank_q <= ~bank_q;
        end else if (done_d) begin
            bank_q <= bank_q ^ (pend_q | swap);
            pend_q <= 1'b0;
        end else if (swap) begin
            pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ready && (32'(wr_col) < COLS))
            mem[~bank_q][wr_col][wr_addr] <= wr_data;
    end
`else
    logic [DW-1:0] mem [COLS][DEPTH];
    logic          unused_swap;

    assign unused_swap = swap;
    assign wr_ready    = ~busy;
    assign bank_sel    = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ready && (32'(wr_col) < COLS))
            mem[wr_col][wr_addr] <= wr_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= '0;
            o_data_q  <= '0;
        end else begin
            for (int unsigned c = 0; c < COLS; c++) begin
                o_valid_q[c] <= col_v[c];
`ifdef WBUF_PINGPONG_EN
                o_data_q[c*DW +: DW] <= col_v[c] ? mem[bank_q][c][col_a[c]] : '0;
`else
                o_data_q[c*DW +: DW] <= col_v[c] ? mem[c][col_a[c]] : '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_skewed_weight_buffer.sv
// Randomized self-checking bench for skewed_weight_buffer (COLS=4, DW=8, DEPTH=16).
// Expected outputs come from a per-tile timing rule over a reference memory image.
module tb_skewed_weight_buffer;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(COLS);
`ifdef WBUF_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, wr_en, start, swap;
    logic [CW-1:0]        wr_col;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [AW:0]          len;
    logic                 wr_ready, busy, done, bank_sel;
    logic [COLS-1:0]      o_valid;
    logic [COLS*DW-1:0]   o_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DW-1:0] refmem [2][COLS][DEPTH];
    bit            mbank = 1'b0;

    skewed_weight_buffer #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .len(len), .swap(swap),
        .busy(busy), .done(done), .bank_sel(bank_sel), .o_valid(o_valid), .o_data(o_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int unsigned c, input int unsigned a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_col  = CW'(c);
        wr_addr = AW'(a);
        wr_data = d;
        check("wr_ready_idle", 64'(wr_ready), 64'(1));
        tick();
        wr_en = 1'b0;
        refmem[mbank ^ PP][c][a] = d;
    endtask

`ifdef WBUF_PINGPONG_EN
    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap  = 1'b0;
        mbank = ~mbank;
        check("bank_swap_idle", 64'(bank_sel), 64'(mbank));
    endtask
`endif

    // One tile: column c presents word k after edge E0+1+k+c, done at E0+eff+COLS.
    task automatic run_tile(input int unsigned ln, input bit swap0, input bit hold,
                            input bit wr_mode, input logic [DW-1:0] wr_val,
                            input int unsigned swap_at, input int unsigned rst_at);
        int unsigned     eff;
        bit              rb, pend;
        logic [COLS-1:0] ev;
        logic [COLS*DW-1:0] ed;
        eff   = (ln > DEPTH) ? DEPTH : ln;
        start = 1'b1;
        len   = ln[AW:0];
        swap  = swap0;
        tick();
        start = hold;
        swap  = 1'b0;
        if (swap0 && PP) mbank = ~mbank;
        if (eff == 0) begin
            start = 1'b0;
            check("busy_len0", 64'(busy), 64'(0));
            for (int i = 0; i < 3; i++) begin
                tick();
                check("done_len0", 64'(done), 64'(0));
                check("valid_len0", 64'(o_valid), 64'(0));
            end
            return;
        end
        check("busy_e0", 64'(busy), 64'(1));
        check("valid_e0", 64'(o_valid), 64'(0));
        check("bank_e0", 64'(bank_sel), 64'(mbank));
        rb   = mbank;
        pend = 1'b0;
        for (int unsigned t = 1; t <= eff + COLS; t++) begin
            if (wr_mode) begin
                wr_en   = 1'b1;
                wr_col  = CW'((t - 1) % COLS);
                wr_addr = AW'((t - 1) / COLS);
                wr_data = wr_val;
                check("wr_ready_busy", 64'(wr_ready), 64'(PP));
            end
            if (t == swap_at) swap = 1'b1;
            if (t == rst_at) rst = 1'b1;
            tick();
            if (wr_mode && PP) refmem[~rb][(t - 1) % COLS][(t - 1) / COLS] = wr_val;
            wr_en = 1'b0;
            swap  = 1'b0;
            if (t == swap_at && PP) pend = 1'b1;
            if (t == rst_at) begin
                rst   = 1'b0;
                start = 1'b0;
                mbank = 1'b0;
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_valid", 64'(o_valid), 64'(0));
                check("rst_data", 64'(o_data), 64'(0));
                check("rst_bank", 64'(bank_sel), 64'(0));
                for (int i = 0; i < eff + COLS; i++) begin
                    tick();
                    check("rst_no_done", 64'(done), 64'(0));
                    check("rst_no_valid", 64'(o_valid), 64'(0));
                end
                return;
            end
            ev = '0;
            ed = '0;
            for (int unsigned c = 0; c < COLS; c++) begin
                if (t >= 1 + c && t <= eff + c) begin
                    ev[c] = 1'b1;
                    ed[c*DW +: DW] = refmem[rb][c][t - 1 - c];
                end
            end
            check("valid", 64'(o_valid), 64'(ev));
            check("data", 64'(o_data), 64'(ed));
            check("done", 64'(done), 64'(t == eff + COLS));
            check("busy", 64'(busy), 64'(t < eff + COLS));
            if (t == eff + COLS && pend) mbank = ~mbank;
            check("bank", 64'(bank_sel), 64'(mbank));
        end
    endtask

    task automatic fill_pattern();
        for (int unsigned c = 0; c < COLS; c++)
            for (int unsigned a = 0; a < DEPTH; a++)
                do_write(c, a, DW'(16 * c + a));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; swap = 1'b0;
        wr_col = '0; wr_addr = '0; wr_data = '0; len = '0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < COLS; c++)
                for (int a = 0; a < DEPTH; a++)
                    refmem[b][c][a] = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_bank", 64'(bank_sel), 64'(0));
        check("reset_valid", 64'(o_valid), 64'(0));
        check("reset_data", 64'(o_data), 64'(0));

        fill_pattern();
`ifdef WBUF_PINGPONG_EN
        do_swap();
        fill_pattern();
`endif
        run_tile(16, 1'b0, 1'b0, 1'b0, '0, 0, 0);
        run_tile(0, 1'b0, 1'b0, 1'b0, '0, 0, 0);
        run_tile(20, 1'b0, 1'b0, 1'b0, '0, 0, 0);
        run_tile(16, 1'b0, 1'b1, 1'b0, '0, 0, 0);
        run_tile(16, 1'b0, 1'b0, 1'b0, '0, 0, 0);
`ifndef WBUF_PINGPONG_EN
        run_tile(16, 1'b0, 1'b0, 1'b1, 8'hAA, 0, 0);
        run_tile(4, 1'b0, 1'b0, 1'b0, '0, 0, 0);
`endif
        run_tile(16, 1'b0, 1'b0, 1'b0, '0, 0, 5);
        run_tile(4, 1'b0, 1'b0, 1'b0, '0, 0, 0);
`ifdef WBUF_PINGPONG_EN
        run_tile(16, 1'b0, 1'b0, 1'b1, 8'h5A, 2, 0);
        run_tile(4, 1'b0, 1'b0, 1'b0, '0, 0, 0);
        run_tile(6, 1'b1, 1'b0, 1'b0, '0, 0, 0);
`endif

        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 6; w++)
                do_write($urandom_range(0, COLS - 1), $urandom_range(0, DEPTH - 1), DW'($urandom));
            run_tile($urandom_range(0, 2 * DEPTH - 1), 1'($urandom_range(0, 1)), 1'b0,
                     1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 8), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
